instr_feeder: RTL and testbench

//  Upstream instruction source for simple_processor: holds a small loadable program RAM, sequences it

---
 rtl/instr_feeder.sv | 169 ++++++++++++++++
 tb/tb_instr_feeder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_feeder.sv
// Program RAM sequencer that feeds simple_processor one instruction (plus mvi immediate) per done handshake.
// Optional watchdog on the done wait is compiled in with `define FEEDER_WDOG_EN.
module instr_feeder #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              done,
    output logic [DATA_W-1:0] din,
    output logic              run,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {IDLE, ISSUE, IMM, WAIT, HALT} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] din_nx;
    logic              run_nx;
    logic              busy_nx;
    logic              halted_nx;
    logic              mvi_q, mvi_nx;
    logic [ADDR_W:0]   len_q, len_nx;
    // Instruction count; pc is its low bits so long programs wrap the address
    logic [ADDR_W:0]   cnt_q, cnt_nx;
    logic [ADDR_W+1:0] step_sum;
    logic              load_ok;

`ifdef FEEDER_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_nx;
    logic            err_q, err_nx;
`endif

    function automatic logic is_mvi(input logic [DATA_W-1:0] word);
        return word[DATA_W-1 -: 2] == 2'b01;
    endfunction

    assign load_ok  = (state == IDLE) || (state == HALT);
    assign step_sum = {1'b0, cnt_q} + (mvi_q ? (ADDR_W+2)'(2) : (ADDR_W+2)'(1));
    assign pc       = cnt_q[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (ld_en && load_ok)
            mem[ld_addr] <= ld_data;
    end

    always_comb begin
        state_nx = state;
        din_nx   = din;
        run_nx   = 1'b0;
        mvi_nx   = mvi_q;
        len_nx   = len_q;
        cnt_nx   = cnt_q;
`ifdef FEEDER_WDOG_EN
        wd_nx    = wd_q;
        err_nx   = err_q;
`endif
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    len_nx = prog_len;
                    cnt_nx = '0;
`ifdef FEEDER_WDOG_EN
                    err_nx = 1'b0;
`endif
                    if (prog_len == '0) begin
                        state_nx = HALT;
                    end else begin
                        state_nx = ISSUE;
                        din_nx   = mem[0];
                        run_nx   = 1'b1;
                        mvi_nx   = is_mvi(mem[0]);
                    end
                end
            end
            ISSUE: begin
`ifdef FEEDER_WDOG_EN
                wd_nx = '0;
`endif
                if (mvi_q) begin
                    state_nx = IMM;
                    din_nx   = mem[ADDR_W'(cnt_q[ADDR_W-1:0] + 1'b1)];
                end else begin
                    state_nx = WAIT;
                end
            end
            IMM: begin
`ifdef FEEDER_WDOG_EN
                wd_nx = '0;
`endif
                state_nx = WAIT;
            end
            WAIT: begin
                if (done) begin
                    cnt_nx = step_sum[ADDR_W:0];
                    if (step_sum >= {1'b0, len_q}) begin
                        state_nx = HALT;
                    end else begin
                        state_nx = ISSUE;
                        din_nx   = mem[step_sum[ADDR_W-1:0]];
                        run_nx   = 1'b1;
                        mvi_nx   = is_mvi(mem[step_sum[ADDR_W-1:0]]);
                    end
                end
`ifdef FEEDER_WDOG_EN
                else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    err_nx   = 1'b1;
                    state_nx = HALT;
                end else begin
                    wd_nx = wd_q + 1'b1;
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
        busy_nx   = (state_nx == ISSUE) || (state_nx == IMM) || (state_nx == WAIT);
        halted_nx = (state_nx == HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            din    <= '0;
            run    <= 1'b0;
            busy   <= 1'b0;
            halted <= 1'b0;
            mvi_q  <= 1'b0;
            len_q  <= '0;
            cnt_q  <= '0;
`ifdef FEEDER_WDOG_EN
            wd_q   <= '0;
            err_q  <= 1'b0;
`endif
        end else begin
            state  <= state_nx;
            din    <= din_nx;
            run    <= run_nx;
            busy   <= busy_nx;
            halted <= halted_nx;
            mvi_q  <= mvi_nx;
            len_q  <= len_nx;
            cnt_q  <= cnt_nx;
`ifdef FEEDER_WDOG_EN
            wd_q   <= wd_nx;
            err_q  <= err_nx;
`endif
        end
    end

`ifdef FEEDER_WDOG_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_feeder.sv
// Scoreboard bench for instr_feeder: expected issues are queued by the stimulus, a monitor checks each run pulse.
module tb_instr_feeder;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic          done = 1'b0;
    logic [DW-1:0] din;
    logic          run;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;
    logic          err;

    instr_feeder #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .prog_len(prog_len), .start(start), .done(done), .din(din), .run(run), .pc(pc),
        .busy(busy), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] instr;
        bit            has_imm;
        logic [DW-1:0] imm;
    } exp_t;

    exp_t exq[$];
    exp_t cur;
    int   nvec = 0;
    int   nmis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic push(input logic [AW-1:0] p, input logic [DW-1:0] i, input bit h, input logic [DW-1:0] m);
        exp_t e;
        e.pc = p; e.instr = i; e.has_imm = h; e.imm = m;
        exq.push_back(e);
    endtask

    // Monitor: every run pulse must match the head of the queue; an mvi's immediate follows next cycle
    bit            imm_pend = 1'b0;
    logic [DW-1:0] imm_exp = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            imm_pend = 1'b0;
        end else if (imm_pend) begin
            check("imm_din", din, imm_exp);
            check("imm_run_low", run, 0);
            imm_pend = 1'b0;
        end else if (run) begin
            if (exq.size() == 0) begin
                nvec++;
                nmis++;
                $display("FAIL unexpected_run: got run at pc %0h din %0h, expected none", pc, din);
            end else begin
                cur = exq.pop_front();
                check("run_pc", pc, cur.pc);
                check("run_din", din, cur.instr);
                if (cur.has_imm) begin
                    imm_pend = 1'b1;
                    imm_exp  = cur.imm;
                end
            end
        end
    end

    // Processor stand-in: raises done resp_delay cycles after a run pulse
    int resp_delay = 2;
    int cd = 0;
    bit done_hold = 1'b0;
    bit done_never = 1'b0;
    always @(negedge clk) begin
        if (run) cd = 0;
        else if (busy) cd++;
        else cd = 0;
        if (done_never) done = 1'b0;
        else if (done_hold) done = 1'b1;
        else done = busy && !run && (cd >= resp_delay);
    end

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic go(input logic [AW:0] len);
        @(negedge clk);
        prog_len = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        for (int i = 0; i < budget && !halted; i++) @(negedge clk);
        check("halt_reached", halted, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_din", din, 0);
        check("rst_run", run, 0);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;

        // Two mvi's and an add
        load(0, 8'h40); load(1, 8'h05); load(2, 8'h48); load(3, 8'h07); load(4, 8'h81);
        push(0, 8'h40, 1, 8'h05);
        push(2, 8'h48, 1, 8'h07);
        push(4, 8'h81, 0, 8'h00);
        go(5);
        wait_halt(200);
        check("p1_pc", pc, 5);
        check("p1_busy", busy, 0);
        check("p1_din", din, 8'h81);
        repeat (3) @(negedge clk);
        check("p1_pc_hold", pc, 5);
        check("p1_halted_hold", halted, 1);
        check("p1_drained", exq.size(), 0);

        // Reset in the middle of the same program
        push(0, 8'h40, 1, 8'h05);
        push(2, 8'h48, 1, 8'h07);
        go(5);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_din", din, 0);
        check("mid_rst_run", run, 0);
        check("mid_rst_pc", pc, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_halted", halted, 0);
        check("mid_rst_err", err, 0);
        exq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_busy", busy, 0);

        // Empty program halts at once without a run pulse
        go(0);
        check("len0_halted", halted, 1);
        check("len0_busy", busy, 0);
        check("len0_pc", pc, 0);
        repeat (3) @(negedge clk);

        // Write attempted during WAIT must be dropped; done never comes
        load(0, 8'h81);
        done_never = 1'b1;
        push(0, 8'h81, 0, 8'h00);
        go(1);
        repeat (2) @(negedge clk);
        load(0, 8'hFF);
        repeat (18) @(negedge clk);
`ifdef FEEDER_WDOG_EN
        check("wdog_err", err, 1);
        check("wdog_halted", halted, 1);
        check("wdog_busy", busy, 0);
`else
        check("nowd_busy", busy, 1);
        check("nowd_err", err, 0);
        check("nowd_halted", halted, 0);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
`endif
        done_never = 1'b0;
        push(0, 8'h81, 0, 8'h00);
        go(1);
        check("restart_err", err, 0);
        wait_halt(100);
        check("ram_kept_pc", pc, 1);
        check("ram_kept_din", din, 8'h81);

        // done held high: ignored in ISSUE/IMM, back-to-back issue otherwise
        load(0, 8'h40); load(1, 8'h33); load(2, 8'h81); load(3, 8'h82);
        done_hold = 1'b1;
        push(0, 8'h40, 1, 8'h33);
        push(2, 8'h81, 0, 8'h00);
        push(3, 8'h82, 0, 8'h00);
        go(4);
        repeat (6) @(negedge clk);
        check("b2b_not_yet_halted", halted, 0);
        @(negedge clk);
        check("b2b_halted", halted, 1);
        check("b2b_pc", pc, 4);
        done_hold = 1'b0;

        // Length beyond depth: mvi at 15 takes its immediate from address 0
        for (int a = 0; a < 16; a++)
            load(AW'(a), (a == 15) ? 8'h40 : ((a == 0) ? 8'h09 : 8'h00));
        resp_delay = 1;
        push(0, 8'h09, 0, 8'h00);
        for (int a = 1; a < 15; a++) push(AW'(a), 8'h00, 0, 8'h00);
        push(15, 8'h40, 1, 8'h09);
        go(17);
        wait_halt(400);
        check("wrap_pc", pc, 1);
        check("wrap_din", din, 8'h09);
        check("wrap_busy", busy, 0);

        repeat (2) @(negedge clk);
        check("final_drained", exq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
